// File: rtl/key_scanner.sv
// key_scanner -- debounced multi-key scanner with a single-entry event register.
//
// Each raw key level is synchronized, then debounced by a per-key four-state
// FSM. Accepted level changes produce one-cycle press/release pulses, a
// running press total, and a single held event that a consumer drains with a
// valid/ready handshake. Events that cannot be captured set a sticky overflow.
//
// Ports:
//   clock        in   rising-edge clock for all state
//   reset        in   asynchronous, active-high reset
//   keys_in      in   [KEYS]   raw key levels, 1 = pressed
//   keys_stable  out  [KEYS]   debounced key levels
//   key_press    out  [KEYS]   one-cycle pulse on an accepted 0->1 change
//   key_release  out  [KEYS]   one-cycle pulse on an accepted 1->0 change
//   press_count  out  [CNT_W]  wrapping total of accepted presses
//   event_valid  out           event register holds an event
//   event_key    out  [EW]     key index of the held event
//   event_kind   out           1 = press, 0 = release
//   event_ready  in            consumer accepts the held event
//   overflow     out           sticky: an event was lost
//   clear_ovf    in            synchronous clear of overflow (a new loss wins)
module key_scanner #(
  parameter int KEYS     = 4,
  parameter int DEBOUNCE = 16,
  parameter int CNT_W    = 8,
  localparam int EW      = (KEYS > 1) ? $clog2(KEYS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [KEYS-1:0]  keys_in,
  output logic [KEYS-1:0]  keys_stable,
  output logic [KEYS-1:0]  key_press,
  output logic [KEYS-1:0]  key_release,
  output logic [CNT_W-1:0] press_count,
  output logic             event_valid,
  output logic [EW-1:0]    event_key,
  output logic             event_kind,
  input  logic             event_ready,
  output logic             overflow,
  input  logic             clear_ovf
);

  // The counter only needs to reach DEBOUNCE-1.
  localparam int            CW       = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    UP       = 2'd0,
    ARM_DOWN = 2'd1,
    DOWN     = 2'd2,
    ARM_UP   = 2'd3
  } key_state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer on every raw key input
  // ---------------------------------------------------------------------------
  logic [KEYS-1:0] sync1_q, sync2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keys_in;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce FSMs
  // ---------------------------------------------------------------------------
  key_state_e      state_q   [KEYS];
  key_state_e      state_nxt [KEYS];
  logic [CW-1:0]   cnt_q     [KEYS];
  logic [CW-1:0]   cnt_nxt   [KEYS];
  logic [KEYS-1:0] press_nxt, release_nxt;

  // State register. Pulses are registered together with the state so they
  // line up with the keys_stable change decoded from the new state.
  // NOTE: these per-key arrays are plain flops, not RAM, so they are reset
  // explicitly; a mid-debounce reset must discard the partial count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < KEYS; k++) begin
        state_q[k] <= UP;
        cnt_q[k]   <= '0;
      end
      key_press   <= '0;
      key_release <= '0;
    end else begin
      for (int k = 0; k < KEYS; k++) begin
        state_q[k] <= state_nxt[k];
        cnt_q[k]   <= cnt_nxt[k];
      end
      key_press   <= press_nxt;
      key_release <= release_nxt;
    end
  end

  // Next-state logic. A level opposite to the stable one must be seen for
  // DEBOUNCE consecutive cycles; any return to the stable level disarms.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    press_nxt   = '0;
    release_nxt = '0;
    for (int k = 0; k < KEYS; k++) begin
      state_nxt[k] = state_q[k];
      cnt_nxt[k]   = cnt_q[k];
      unique case (state_q[k])
        UP: begin
          if (sync2_q[k]) begin
            state_nxt[k] = ARM_DOWN;
            cnt_nxt[k]   = CW'(1);
          end
        end
        ARM_DOWN: begin
          if (!sync2_q[k]) begin
            state_nxt[k] = UP;
            cnt_nxt[k]   = '0;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_nxt[k] = DOWN;
            cnt_nxt[k]   = '0;
            press_nxt[k] = 1'b1;
          end else begin
            cnt_nxt[k] = cnt_q[k] + CW'(1);
          end
        end
        DOWN: begin
          if (!sync2_q[k]) begin
            state_nxt[k] = ARM_UP;
            cnt_nxt[k]   = CW'(1);
          end
        end
        ARM_UP: begin
          if (sync2_q[k]) begin
            state_nxt[k] = DOWN;
            cnt_nxt[k]   = '0;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_nxt[k]   = UP;
            cnt_nxt[k]     = '0;
            release_nxt[k] = 1'b1;
          end else begin
            cnt_nxt[k] = cnt_q[k] + CW'(1);
          end
        end
      endcase
    end
  end

  // Output decode: the key reads as pressed in DOWN and while arming release.
  always_comb begin
    keys_stable = '0;
    for (int k = 0; k < KEYS; k++) begin
      keys_stable[k] = (state_q[k] == DOWN) || (state_q[k] == ARM_UP);
    end
  end

  // ---------------------------------------------------------------------------
  // Press counter and event register, fed from the visible pulses
  // ---------------------------------------------------------------------------
  logic [KEYS-1:0]  pulses;
  logic             pulse_any;
  logic             multi_pulse;
  logic [EW-1:0]    sel_key;
  logic             sel_kind;
  logic [CNT_W-1:0] press_pop;
  logic             load_en;
  logic             loss;

  always_comb begin
    pulses      = key_press | key_release;
    pulse_any   = |pulses;
    // More than one bit set: clearing the lowest set bit leaves something.
    multi_pulse = (pulses & (pulses - KEYS'(1))) != '0;
    sel_key     = '0;
    sel_kind    = 1'b0;
    press_pop   = '0;
    // Scan downwards so the lowest-index pulsing key is the last one written.
    for (int k = KEYS - 1; k >= 0; k--) begin
      if (pulses[k]) begin
        sel_key  = EW'(k);
        sel_kind = key_press[k];
      end
    end
    for (int k = 0; k < KEYS; k++) begin
      press_pop = press_pop + CNT_W'(key_press[k]);
    end
    load_en = !event_valid || event_ready;
    loss    = (pulse_any && !load_en) || multi_pulse;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press_count <= '0;
      event_valid <= 1'b0;
      event_key   <= '0;
      event_kind  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      press_count <= press_count + press_pop;
      if (load_en) begin
        event_valid <= pulse_any;
        // Key and kind are left alone when the register simply empties.
        if (pulse_any) begin
          event_key  <= sel_key;
          event_kind <= sel_kind;
        end
      end
      if (loss) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_scanner.sv
// Self-checking bench for key_scanner (KEYS=4, DEBOUNCE=4, CNT_W=8).
// A behavioural model tracks, per key, how many consecutive synchronized
// samples disagree with the accepted level; every output is compared after
// every clock edge, plus directed checks at the interesting points.
module tb_key_scanner;
  localparam int KEYS     = 4;
  localparam int DEBOUNCE = 4;
  localparam int CNT_W    = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [KEYS-1:0]  keys_in = '0;
  logic             event_ready = 1'b0;
  logic             clear_ovf = 1'b0;
  logic [KEYS-1:0]  keys_stable, key_press, key_release;
  logic [CNT_W-1:0] press_count;
  logic             event_valid, event_kind, overflow;
  logic [1:0]       event_key;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  key_scanner #(.KEYS(KEYS), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .keys_in     (keys_in),
    .keys_stable (keys_stable),
    .key_press   (key_press),
    .key_release (key_release),
    .press_count (press_count),
    .event_valid (event_valid),
    .event_key   (event_key),
    .event_kind  (event_kind),
    .event_ready (event_ready),
    .overflow    (overflow),
    .clear_ovf   (clear_ovf)
  );

  // Reference model state
  bit [KEYS-1:0] m_s1, m_s2, m_stable, m_press, m_release;
  int            m_run [KEYS];
  int            m_count;
  bit            m_valid, m_kind, m_ovf;
  int            m_key;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int popcount(input bit [KEYS-1:0] v);
    int n = 0;
    for (int k = 0; k < KEYS; k++) n += int'(v[k]);
    return n;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0; m_release = '0;
    for (int k = 0; k < KEYS; k++) m_run[k] = 0;
    m_count = 0; m_valid = 0; m_kind = 0; m_ovf = 0; m_key = 0;
  endtask

  task automatic model_edge();
    bit [KEYS-1:0] pl, np, nr;
    int n, low;
    bit held;
    pl   = m_press | m_release;
    n    = popcount(pl);
    low  = 0;
    for (int k = KEYS - 1; k >= 0; k--) if (pl[k]) low = k;
    held = m_valid && !event_ready;
    if (!held) begin
      if (n > 0) begin
        m_valid = 1; m_key = low; m_kind = m_press[low];
      end else begin
        m_valid = 0;
      end
    end
    if ((n > 0 && held) || n > 1) m_ovf = 1;
    else if (clear_ovf) m_ovf = 0;
    m_count = (m_count + popcount(m_press)) % 256;
    np = '0; nr = '0;
    for (int k = 0; k < KEYS; k++) begin
      if (m_s2[k] != m_stable[k]) begin
        m_run[k]++;
        if (m_run[k] == DEBOUNCE) begin
          m_stable[k] = m_s2[k];
          if (m_s2[k]) np[k] = 1; else nr[k] = 1;
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = keys_in;
    m_press = np;
    m_release = nr;
  endtask

  task automatic compare_all();
    check("keys_stable", 32'(keys_stable), 32'(m_stable));
    check("key_press",   32'(key_press),   32'(m_press));
    check("key_release", 32'(key_release), 32'(m_release));
    check("press_count", 32'(press_count), 32'(m_count));
    check("event_valid", 32'(event_valid), 32'(m_valid));
    check("event_key",   32'(event_key),   32'(m_key));
    check("event_kind",  32'(event_kind),  32'(m_kind));
    check("overflow",    32'(overflow),    32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int edge_no;
    bit found;

    // Reset state
    model_reset();
    ticks(3);
    check("reset_count", 32'(press_count), 32'd0);
    reset = 1'b0;
    event_ready = 1'b1;

    // Glitch of 3 cycles on key 2: ignored
    keys_in[2] = 1'b1;
    ticks(3);
    keys_in[2] = 1'b0;
    ticks(10);
    check("glitch_stable", 32'(keys_stable), 32'd0);
    check("glitch_count",  32'(press_count), 32'd0);

    // Single press on key 0: pulse 6 edges after the input change
    keys_in[0] = 1'b1;
    edge_no = 0;
    found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (key_press[0] === 1'b1) begin
        found = 1;
        edge_no = i;
      end
    end
    check("press0_latency", 32'(edge_no), 32'd6);
    check("press0_stable",  32'(keys_stable), 32'b0001);
    tick();
    check("press0_ev_valid", 32'(event_valid), 32'd1);
    check("press0_ev_key",   32'(event_key),   32'd0);
    check("press0_ev_kind",  32'(event_kind),  32'd1);
    check("press0_count",    32'(press_count), 32'd1);
    tick();
    check("press0_ev_drain", 32'(event_valid), 32'd0);

    // Back-pressure: key 1 held in the register, key 3 lost
    event_ready = 1'b0;
    keys_in[1] = 1'b1;
    ticks(10);
    check("bp_valid", 32'(event_valid), 32'd1);
    check("bp_ovf0",  32'(overflow),    32'd0);
    keys_in[3] = 1'b1;
    ticks(10);
    check("bp_key",   32'(event_key),   32'd1);
    check("bp_kind",  32'(event_kind),  32'd1);
    check("bp_ovf1",  32'(overflow),    32'd1);
    check("bp_count", 32'(press_count), 32'd3);
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    check("bp_drain",  32'(event_valid), 32'd0);
    check("bp_sticky", 32'(overflow),    32'd1);
    ticks(3);
    check("bp_sticky2", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("bp_clear", 32'(overflow), 32'd0);

    // Release keys 1 and 3 together, then press keys 1 and 2 together
    event_ready = 1'b1;
    keys_in = 4'b0001;
    ticks(10);
    check("rel_ovf", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    keys_in = 4'b0111;
    ticks(7);
    check("dual_valid", 32'(event_valid), 32'd1);
    check("dual_key",   32'(event_key),   32'd1);
    check("dual_kind",  32'(event_kind),  32'd1);
    check("dual_ovf",   32'(overflow),    32'd1);
    check("dual_count", 32'(press_count), 32'd5);
    ticks(3);

    // Randomized traffic, checked cycle by cycle against the model
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) keys_in = 4'($urandom);
      event_ready = 1'($urandom_range(0, 1));
      clear_ovf   = ($urandom_range(0, 7) == 0);
      tick();
    end
    keys_in = '0;
    event_ready = 1'b1;
    clear_ovf = 1'b0;
    ticks(12);

    // Bring the counter to 255, then wrap it with one more press
    for (int i = 0; i < 300 && m_count != 255; i++) begin
      keys_in[0] = 1'b1;
      ticks(7);
      keys_in[0] = 1'b0;
      ticks(7);
    end
    check("wrap_pre", 32'(press_count), 32'd255);
    keys_in[0] = 1'b1;
    ticks(8);
    check("wrap", 32'(press_count), 32'd0);

    // Reset mid-debounce with an event pending
    keys_in = '0;
    ticks(10);
    event_ready = 1'b0;
    keys_in[1] = 1'b1;
    ticks(10);
    check("rst_pending", 32'(event_valid), 32'd1);
    keys_in[2] = 1'b1;
    ticks(2);
    reset = 1'b1;
    #1;
    check("rst_stable",  32'(keys_stable), 32'd0);
    check("rst_press",   32'(key_press),   32'd0);
    check("rst_release", 32'(key_release), 32'd0);
    check("rst_count",   32'(press_count), 32'd0);
    check("rst_valid",   32'(event_valid), 32'd0);
    check("rst_key",     32'(event_key),   32'd0);
    check("rst_kind",    32'(event_kind),  32'd0);
    check("rst_ovf",     32'(overflow),    32'd0);
    model_reset();
    keys_in = '0;
    ticks(2);
    reset = 1'b0;
    ticks(20);
    check("post_rst_count", 32'(press_count), 32'd0);
    check("post_rst_valid", 32'(event_valid), 32'd0);

    // Key held through reset deassertion
    reset = 1'b1;
    keys_in[3] = 1'b1;
    tick();
    reset = 1'b0;
    edge_no = 0;
    found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (key_press[3] === 1'b1) begin
        found = 1;
        edge_no = i;
      end
    end
    check("held_latency", 32'(edge_no), 32'd6);
    ticks(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
